// File: rtl/paddle_ctl_multi_if.sv
// Bus bundle for paddle_ctl_multi: analog/button sources in, pot values, fire bits and source selects out.
interface paddle_ctl_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  logic                               ce;
  logic [NUM_CH-1:0]                  inv;
  logic [NUM_CH-1:0]                  stick_btn;
  logic [NUM_CH-1:0][1:0][DATA_W-1:0] joy_a;      // [ch][1]=Y, [ch][0]=X
  logic [NUM_CH-1:0]                  paddle_btn;
  logic [NUM_CH-1:0][DATA_W-1:0]      paddle;
  logic [24:0]                        ps2_mouse;
  logic [NUM_CH-1:0]                  b_out;
  logic [NUM_CH-1:0][DATA_W-1:0]      a_out;
  logic [NUM_CH-1:0][1:0]             src;

  modport master (
    output ce, inv, stick_btn, joy_a, paddle_btn, paddle, ps2_mouse,
    input  b_out, a_out, src
  );
  modport slave (
    input  ce, inv, stick_btn, joy_a, paddle_btn, paddle, ps2_mouse,
    output b_out, a_out, src
  );
endinterface

// File: rtl/paddle_ctl_multi.sv
// Multi-channel analog front end: per-channel source select (paddle/stick/mouse), offset-binary
// pot value with optional slew limiting, and fire bit. One shared PS/2 mouse accumulator pair.
module paddle_ch #(
  parameter int DATA_W      = 8,
  parameter int AXIS_THRESH = 100,
  parameter int SLEW        = 0,
  parameter bit IS_MOUSE    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic                   inv,
  input  logic                   stick_btn,
  input  logic                   paddle_btn,
  input  logic                   mouse_ev,
  input  logic [1:0][DATA_W-1:0] joy,
  input  logic [DATA_W-1:0]      paddle,
  input  logic [DATA_W-1:0]      mx,
  input  logic [DATA_W-1:0]      my,
  input  logic [1:0]             mouse_btn,
  output logic                   b_out,
  output logic [DATA_W-1:0]      a_out,
  output logic [1:0]             src
);
  typedef enum logic [1:0] {S_PADDLE = 2'd0, S_STICK = 2'd1, S_MOUSE = 2'd2} src_t;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(SLEW);

  src_t              state;
  logic              xy;
  logic [DATA_W-1:0] target, pre, off;
  logic              x_hit, y_hit;

  // An axis only counts when pushed hard in the positive direction.
  assign x_hit = ~joy[0][DATA_W-1] && (joy[0][DATA_W-1 -: 8] > 8'(AXIS_THRESH));
  assign y_hit = ~joy[1][DATA_W-1] && (joy[1][DATA_W-1 -: 8] > 8'(AXIS_THRESH));

  assign pre = (state == S_STICK) ? (xy ? joy[1] : joy[0]) :
               (state == S_MOUSE) ? (xy ? my : mx) : paddle;
  assign off = {~pre[DATA_W-1], pre[DATA_W-2:0]};
  assign src = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_PADDLE;
      xy     <= 1'b0;
      target <= '0;
      b_out  <= 1'b0;
      a_out  <= '0;
    end else begin
      if (paddle_btn)              state <= S_PADDLE;
      else if (stick_btn)          state <= S_STICK;
      else if (IS_MOUSE && mouse_ev) state <= S_MOUSE;

      case (state)
        S_STICK: begin
          if (x_hit)      xy <= 1'b0;
          else if (y_hit) xy <= 1'b1;
        end
        S_MOUSE: begin
          if (mouse_btn[0])      xy <= 1'b0;
          else if (mouse_btn[1]) xy <= 1'b1;
        end
        default: ;
      endcase

      target <= inv ? ~off : off;

      case (state)
        S_STICK: b_out <= stick_btn;
        S_MOUSE: b_out <= |mouse_btn;
        default: b_out <= paddle_btn;
      endcase

      // Limiter steps from the current a_out, so a source switch never jumps.
      if (SLEW == 0) a_out <= target;
      else if (ce) begin
        if (target > a_out) a_out <= (target - a_out <= STEP) ? target : a_out + STEP;
        else                a_out <= (a_out - target <= STEP) ? target : a_out - STEP;
      end
    end
  end
endmodule

module paddle_ctl_multi #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int MOUSE_CH    = 0,
  parameter int MOUSE_MAX   = 10,
  parameter int AXIS_THRESH = 100,
  parameter int SLEW        = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  paddle_ctl_multi_if.slave bus
);
  localparam int AW = DATA_W + 1;
  localparam logic signed [AW:0]  HI   = (AW+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [AW:0]  LO   = -(AW+1)'(1 << (DATA_W-1));
  localparam logic signed [8:0]   MMAX = 9'(MOUSE_MAX);

  logic                 primed, strobe_q, mouse_ev;
  logic signed [AW-1:0] mx, my;
  logic signed [8:0]    dx, dy;
  logic                 unused_bits;

  function automatic logic signed [8:0] clamp(input logic signed [8:0] d);
    if (d > MMAX)       return MMAX;
    else if (d < -MMAX) return -MMAX;
    else                return d;
  endfunction

  function automatic logic signed [AW-1:0] acc(input logic signed [AW-1:0] a,
                                               input logic signed [8:0] d);
    logic signed [AW:0] s;
    s = (AW+1)'(a) + (AW+1)'(d);
    if (s > HI)      return AW'(HI);
    else if (s < LO) return AW'(LO);
    else             return AW'(s);
  endfunction

  assign dx          = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
  assign dy          = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
  assign mouse_ev    = primed & (bus.ps2_mouse[24] ^ strobe_q);
  assign unused_bits = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};

  // First clock out of reset only captures the strobe level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed   <= 1'b0;
      strobe_q <= 1'b0;
      mx       <= '0;
      my       <= '0;
    end else begin
      primed   <= 1'b1;
      strobe_q <= bus.ps2_mouse[24];
      if (mouse_ev) begin
        mx <= acc(mx, clamp(dx));
        my <= acc(my, clamp(dy));
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    paddle_ch #(
      .DATA_W(DATA_W), .AXIS_THRESH(AXIS_THRESH), .SLEW(SLEW), .IS_MOUSE(g == MOUSE_CH)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (bus.ce),
      .inv       (bus.inv[g]),
      .stick_btn (bus.stick_btn[g]),
      .paddle_btn(bus.paddle_btn[g]),
      .mouse_ev  (mouse_ev),
      .joy       (bus.joy_a[g]),
      .paddle    (bus.paddle[g]),
      .mx        (mx[DATA_W-1:0]),
      .my        (my[DATA_W-1:0]),
      .mouse_btn (bus.ps2_mouse[1:0]),
      .b_out     (bus.b_out[g]),
      .a_out     (bus.a_out[g]),
      .src       (bus.src[g])
    );
  end
endmodule

// File: tb/tb_paddle_ctl_multi.sv
// Randomised + directed bench: two DUTs (limiter bypassed / SLEW=4) share stimulus and a value-level model.
module tb_paddle_ctl_multi;
  localparam int NC = 4;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     ce;
  logic [NC-1:0]            inv, stick_btn, paddle_btn;
  logic [NC-1:0][1:0][7:0]  joy_a;
  logic [NC-1:0][7:0]       paddle;
  logic [24:0]              ps2;

  paddle_ctl_multi_if #(.NUM_CH(NC), .DATA_W(8)) bf ();
  paddle_ctl_multi_if #(.NUM_CH(NC), .DATA_W(8)) bs ();

  assign bf.ce = ce;         assign bs.ce = ce;
  assign bf.inv = inv;       assign bs.inv = inv;
  assign bf.stick_btn = stick_btn;   assign bs.stick_btn = stick_btn;
  assign bf.paddle_btn = paddle_btn; assign bs.paddle_btn = paddle_btn;
  assign bf.joy_a = joy_a;   assign bs.joy_a = joy_a;
  assign bf.paddle = paddle; assign bs.paddle = paddle;
  assign bf.ps2_mouse = ps2; assign bs.ps2_mouse = ps2;

  paddle_ctl_multi #(.NUM_CH(NC), .DATA_W(8), .MOUSE_CH(0), .MOUSE_MAX(10),
                     .AXIS_THRESH(100), .SLEW(0))
    dut_f (.clk(clk), .reset_n(reset_n), .bus(bf.slave));
  paddle_ctl_multi #(.NUM_CH(NC), .DATA_W(8), .MOUSE_CH(0), .MOUSE_MAX(10),
                     .AXIS_THRESH(100), .SLEW(4))
    dut_s (.clk(clk), .reset_n(reset_n), .bus(bs.slave));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model in plain integers: signed sources, offset = value + 128.
  int m_src[NC], m_xy[NC], m_tgt[NC], m_a0[NC], m_a4[NC], m_b[NC];
  int m_mx, m_my;
  bit m_primed, m_last;

  function automatic int sv8(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  function automatic int mdelta(input logic s, input logic [7:0] v);
    int d;
    d = s ? int'(v) - 256 : int'(v);
    if (d > 10) d = 10;
    if (d < -10) d = -10;
    return d;
  endfunction

  function automatic int sat(input int v);
    return v > 127 ? 127 : (v < -128 ? -128 : v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_src[c] = 0; m_xy[c] = 0; m_tgt[c] = 0; m_a0[c] = 0; m_a4[c] = 0; m_b[c] = 0;
    end
    m_mx = 0; m_my = 0; m_primed = 0; m_last = 0;
  endtask

  task automatic model_step();
    bit ev;
    int pre, off, x, y, d;
    int n_src[NC], n_xy[NC], n_tgt[NC], n_a4[NC], n_b[NC];
    ev = m_primed && (ps2[24] != m_last);
    for (int c = 0; c < NC; c++) begin
      x = sv8(joy_a[c][0]); y = sv8(joy_a[c][1]);
      case (m_src[c])
        1:       pre = m_xy[c] ? y : x;
        2:       pre = m_xy[c] ? m_my : m_mx;
        default: pre = sv8(paddle[c]);
      endcase
      off = pre + 128;
      n_tgt[c] = inv[c] ? 255 - off : off;
      case (m_src[c])
        1:       n_b[c] = stick_btn[c];
        2:       n_b[c] = (ps2[1:0] != 0);
        default: n_b[c] = paddle_btn[c];
      endcase
      n_xy[c] = m_xy[c];
      if (m_src[c] == 1) begin
        if (x > 100) n_xy[c] = 0;
        else if (y > 100) n_xy[c] = 1;
      end else if (m_src[c] == 2) begin
        if (ps2[0]) n_xy[c] = 0;
        else if (ps2[1]) n_xy[c] = 1;
      end
      n_src[c] = m_src[c];
      if (paddle_btn[c]) n_src[c] = 0;
      else if (stick_btn[c]) n_src[c] = 1;
      else if (ev && c == 0) n_src[c] = 2;
      n_a4[c] = m_a4[c];
      if (ce) begin
        d = m_tgt[c] - m_a4[c];
        if (d >= -4 && d <= 4) n_a4[c] = m_tgt[c];
        else n_a4[c] = m_a4[c] + (d > 0 ? 4 : -4);
      end
    end
    for (int c = 0; c < NC; c++) begin
      m_a0[c] = m_tgt[c];
      m_tgt[c] = n_tgt[c]; m_b[c] = n_b[c]; m_xy[c] = n_xy[c];
      m_src[c] = n_src[c]; m_a4[c] = n_a4[c];
    end
    if (ev) begin
      m_mx = sat(m_mx + mdelta(ps2[4], ps2[15:8]));
      m_my = sat(m_my + mdelta(ps2[5], ps2[23:16]));
    end
    m_primed = 1; m_last = ps2[24];
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("src%0d", c), 32'(bf.src[c]), m_src[c]);
      chk($sformatf("b_out%0d", c), 32'(bf.b_out[c]), m_b[c]);
      chk($sformatf("a_out%0d", c), 32'(bf.a_out[c]), m_a0[c]);
      chk($sformatf("a_slew%0d", c), 32'(bs.a_out[c]), m_a4[c]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step(); else model_reset();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; inv = '0; stick_btn = '0; paddle_btn = '0;
    joy_a = '0; paddle = '0; ps2 = '0;
    model_reset();
    #2;
    compare_all();
    tick(); tick();
    chk("reset_a0", 32'(bf.a_out[0]), 32'h0);
    reset_n = 1'b1;

    // Paddle zero -> mid-scale, then inverted.
    tick(); tick();
    chk("pad_a0", 32'(bf.a_out[0]), 32'h80);
    inv[0] = 1'b1;
    tick(); tick();
    chk("pad_inv_a0", 32'(bf.a_out[0]), 32'h7F);
    inv[0] = 1'b0;

    // Simultaneous paddle+stick select: paddle wins.
    paddle_btn[1] = 1'b1; stick_btn[1] = 1'b1;
    tick();
    chk("prio_src1", 32'(bf.src[1]), 32'd0);
    tick();
    chk("prio_b1", 32'(bf.b_out[1]), 32'd1);
    paddle_btn[1] = 1'b0; stick_btn[1] = 1'b0;
    tick();

    // Mouse packets dx=+50 clamp to +10 each, mx saturates at 127.
    ps2[15:8] = 8'd50;
    for (int i = 0; i < 20; i++) begin
      ps2[24] = ~ps2[24];
      tick(); tick();
    end
    tick(); tick();
    chk("mouse_src0", 32'(bf.src[0]), 32'd2);
    chk("mouse_src1", 32'(bf.src[1]), 32'd0);
    chk("mouse_a0", 32'(bf.a_out[0]), 32'hFF);

    // Stick on ch2: Y selects, Y held, then X takes over.
    stick_btn[2] = 1'b1; tick(); stick_btn[2] = 1'b0;
    joy_a[2][1] = 8'h70; joy_a[2][0] = 8'h10;
    tick(); tick(); tick();
    chk("stick_y", 32'(bf.a_out[2]), 32'hF0);
    joy_a[2][1] = 8'h30;
    tick(); tick();
    chk("stick_y_hold", 32'(bf.a_out[2]), 32'hB0);
    joy_a[2][0] = 8'h70;
    tick(); tick(); tick();
    chk("stick_x", 32'(bf.a_out[2]), 32'hF0);
    joy_a[2][0] = 8'h20;
    tick(); tick();
    chk("stick_x_hold", 32'(bf.a_out[2]), 32'hA0);

    // Slew limiter on ch3: 0x80 -> 0x90 in steps of 4, only on ce.
    chk("slew_start", 32'(bs.a_out[3]), 32'h80);
    ce = 1'b0; paddle[3] = 8'h10;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick(); tick();
      chk($sformatf("slew_hold%0d", k), 32'(bs.a_out[3]), 32'h80 + 4 * (k - 1));
      ce = 1'b1; tick(); ce = 1'b0;
      chk($sformatf("slew_step%0d", k), 32'(bs.a_out[3]), 32'h80 + 4 * k);
    end
    ce = 1'b1;

    // Strobe held high across reset release must not look like an event.
    ps2 = '0; ps2[24] = 1'b1;
    async_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("strobe_prime_src0", 32'(bf.src[0]), 32'd0);

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < NC; c++) begin
        paddle_btn[c] = ($urandom_range(0, 15) == 0);
        stick_btn[c]  = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) paddle[c] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) joy_a[c][0] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) joy_a[c][1] = 8'($urandom);
        if ($urandom_range(0, 31) == 0) inv[c] = ~inv[c];
      end
      if ($urandom_range(0, 3) == 0) begin
        ps2[23:0] = 24'($urandom);
        ps2[24]   = ~ps2[24];
      end
      ce = ($urandom_range(0, 1) == 0);
      if (i == 600) async_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
